rr_request_tracker: RTL

//  Upstream feeder for rr_arbiter: per-client tracker of outstanding transactions.
//  - Drives the arbiter's request vector; each bit stays high until the arbiter grants that client.
//  - Consumes the grant vector and monitors per-client wait time, so a bounded-grant
//    (safety) check can run on hardware flags as well as in assertions.

---
 rtl/rr_request_tracker.sv | 85 ++++++++
 1 files changed

// File: rtl/rr_request_tracker.sv
// Per-client outstanding-transaction tracker feeding rr_arbiter.
// Holds request high until granted and flags clients that wait too long for a grant.
module rr_request_tracker #(
  parameter int unsigned CLIENTS = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 31
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [CLIENTS-1:0] push,
  output logic [CLIENTS-1:0] push_ready,
  output logic [CLIENTS-1:0] request,
  input  logic [CLIENTS-1:0] grant,
  output logic [CLIENTS-1:0] starved,
  output logic               starved_any,
  output logic               grant_err
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [WW-1:0] TIMEOUT_C = WW'(TIMEOUT);

  logic [CW-1:0] cnt_q [CLIENTS];
  logic [CW-1:0] cnt_d [CLIENTS];
  logic [WW-1:0] age_q [CLIENTS];
  logic [WW-1:0] age_d [CLIENTS];
  logic          starved_any_q, starved_any_d;
  logic          grant_err_q, grant_err_d;
  logic [CLIENTS-1:0] acc, gnt;

  always_comb begin
    request    = '0;
    push_ready = '0;
    starved    = '0;
    for (int unsigned i = 0; i < CLIENTS; i++) begin
      request[i]    = (cnt_q[i] != '0);
      push_ready[i] = (cnt_q[i] < DEPTH_C);
      starved[i]    = (age_q[i] == TIMEOUT_C);
    end
  end

  assign acc         = push & push_ready;
  assign gnt         = grant & request;
  assign starved_any = starved_any_q;
  assign grant_err   = grant_err_q;

  // Push and grant together cancel out; a push while full is dropped even if a grant frees a slot.
  always_comb begin
    for (int unsigned i = 0; i < CLIENTS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (acc[i] && !gnt[i]) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end else if (gnt[i] && !acc[i]) begin
        cnt_d[i] = cnt_q[i] - CW'(1);
      end

      age_d[i] = age_q[i];
      if (gnt[i] || !request[i]) begin
        age_d[i] = '0;
      end else if (age_q[i] != TIMEOUT_C) begin
        age_d[i] = age_q[i] + WW'(1);
      end
    end
    starved_any_d = starved_any_q | (|starved);
    grant_err_d   = grant_err_q | (|(grant & ~request));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < CLIENTS; i++) begin
        cnt_q[i] <= '0;
        age_q[i] <= '0;
      end
      starved_any_q <= 1'b0;
      grant_err_q   <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      age_q         <= age_d;
      starved_any_q <= starved_any_d;
      grant_err_q   <= grant_err_d;
    end
  end

endmodule
